// File: rtl/qmax_update_ctrl.sv
// Q-max BRAM sequencer: clears every entry after reset, then performs
// pipelined qmax[s] = max(qmax[s], q) updates at one request per cycle,
// forwarding the previous result to cover the BRAM read-after-write hazard.
module qmax_update_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 65536,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_state,
  input  logic [DATA_WIDTH-1:0] i_req_q,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_qmax,
  output logic                  o_rsp_updated,
  output logic                  o_init_busy,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_r,
  output logic                  o_mem_read_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_w,
  output logic                  o_mem_write_en,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_cnt;

  logic                    s1_valid;
  logic [ADDR_WIDTH-1:0]   s1_addr;
  logic [DATA_WIDTH-1:0]   s1_q;

  logic                    fwd_valid;
  logic [ADDR_WIDTH-1:0]   fwd_addr;
  logic [DATA_WIDTH-1:0]   fwd_data;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   cur;
  logic                    wr_cand;
  logic [DATA_WIDTH-1:0]   resolved;

  // IEEE-754 single "a > b": NaN on either side and +0/-0 ties never win.
  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
    logic a_nan;
    logic b_nan;
    logic both_zero;
    a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (a_nan || b_nan || both_zero) begin
      f_gt = 1'b0;
    end else if (a[31] != b[31]) begin
      f_gt = b[31];
    end else if (!a[31]) begin
      f_gt = a[30:0] > b[30:0];
    end else begin
      f_gt = a[30:0] < b[30:0];
    end
  endfunction

  assign o_req_ready = (state == ST_RUN);

  // Stage-0 read issue, stage-1 compare with forwarding, BRAM write mux.
  always_comb begin
    accept         = i_req_valid && o_req_ready;
    o_mem_read_en  = accept;
    o_mem_addr_r   = i_req_state;
    cur            = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : i_mem_data;
    wr_cand        = s1_valid && f_gt(s1_q, cur);
    resolved       = wr_cand ? s1_q : cur;
    o_mem_write_en = 1'b0;
    o_mem_addr_w   = s1_addr;
    o_mem_data     = s1_q;
    if (state == ST_INIT) begin
      o_mem_write_en = !i_rst;
      o_mem_addr_w   = sweep_cnt;
      o_mem_data     = INIT_VALUE;
    end else begin
      o_mem_write_en = wr_cand && !i_rst;
    end
  end

  // Sweep FSM, pipeline registers, forward register and response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_INIT;
      sweep_cnt     <= '0;
      o_init_busy   <= 1'b1;
      s1_valid      <= 1'b0;
      fwd_valid     <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_updated <= 1'b0;
      o_rsp_qmax    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
          if (sweep_cnt == LAST_ADDR) begin
            state       <= ST_RUN;
            o_init_busy <= 1'b0;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_addr <= i_req_state;
        s1_q    <= i_req_q;
      end

      fwd_valid <= s1_valid;
      if (s1_valid) begin
        fwd_addr   <= s1_addr;
        fwd_data   <= resolved;
        o_rsp_qmax <= resolved;
      end
      o_rsp_valid   <= s1_valid;
      o_rsp_updated <= wr_cand;
    end
  end

endmodule

// File: tb/tb_qmax_update_ctrl.sv
// Self-checking bench for qmax_update_ctrl (DEPTH=16) with a BRAM model and
// a real-valued max reference model.
module tb_qmax_update_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_state;
  logic [DW-1:0] req_q;
  logic          rsp_valid;
  logic [DW-1:0] rsp_qmax;
  logic          rsp_updated;
  logic          init_busy;
  logic [AW-1:0] mem_addr_r;
  logic          mem_read_en;
  logic [AW-1:0] mem_addr_w;
  logic          mem_write_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  qmax_update_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_VALUE(32'h0)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_state(req_state), .i_req_q(req_q),
    .o_rsp_valid(rsp_valid), .o_rsp_qmax(rsp_qmax), .o_rsp_updated(rsp_updated),
    .o_init_busy(init_busy),
    .o_mem_addr_r(mem_addr_r), .o_mem_read_en(mem_read_en),
    .o_mem_addr_w(mem_addr_w), .o_mem_write_en(mem_write_en),
    .o_mem_data(mem_wdata), .i_mem_data(mem_rdata)
  );

  // BRAM model: registered read returning pre-write data on collision.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_read_en) mem_rdata <= mem[mem_addr_r];
    if (mem_write_en) mem[mem_addr_w] <= mem_wdata;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: float values as reals, sequential max per state.
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic real to_real(input logic [31:0] x);
    real mag;
    int e;
    e = int'(x[30:23]);
    if (e == 255) mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149.0));
    else mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return x[31] ? -mag : mag;
  endfunction

  typedef struct { logic [31:0] qmax; logic upd; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] qref [DEPTH];

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) qref[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [AW-1:0] s, input logic [31:0] q);
    exp_t e;
    logic [31:0] cur;
    cur   = qref[s];
    e.upd = !is_nan(q) && !is_nan(cur) && (to_real(q) > to_real(cur));
    e.qmax = e.upd ? q : cur;
    qref[s] = e.qmax;
    exp_q.push_back(e);
  endtask

  // Response monitor against the model queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mon_qmax", rsp_qmax, e.qmax);
        chk("mon_upd", 32'(rsp_updated), 32'(e.upd));
      end
    end
  end

  // Starting at a negedge where reset has just been released.
  task automatic init_check();
    for (int k = 0; k < int'(DEPTH); k++) begin
      #1;
      chk("init_we", 32'(mem_write_en), 32'd1);
      chk("init_addr", 32'(mem_addr_w), 32'(k));
      chk("init_data", mem_wdata, 32'h0);
      chk("init_busy", 32'(init_busy), 32'd1);
      chk("init_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("run_ready", 32'(req_ready), 32'd1);
    chk("run_busy", 32'(init_busy), 32'd0);
    chk("run_we_idle", 32'(mem_write_en), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] s;
    logic [31:0]   q;
    logic [31:0]   exp_qmax;
    logic          exp_upd;
  } vec_t;

  vec_t vecs [8];

  task automatic issue_check(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1; req_state = v.s; req_q = v.q;
    if (req_ready) model_apply(v.s, v.q);
    #1;
    chk("rd_en", 32'(mem_read_en), 32'd1);
    chk("rd_addr", 32'(mem_addr_r), 32'(v.s));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("wr_en", 32'(mem_write_en), 32'(v.exp_upd));
    if (v.exp_upd) begin
      chk("wr_addr", 32'(mem_addr_w), 32'(v.s));
      chk("wr_data", mem_wdata, v.q);
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_qmax", rsp_qmax, v.exp_qmax);
    chk("rsp_upd", 32'(rsp_updated), 32'(v.exp_upd));
  endtask

  logic [31:0] pool [10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'd3, 32'h3F800000, 32'h3F800000, 1'b1};
    vecs[1] = '{4'd3, 32'hBF800000, 32'h3F800000, 1'b0};
    vecs[2] = '{4'd4, 32'h80000000, 32'h00000000, 1'b0};
    vecs[3] = '{4'd7, 32'h7FC00000, 32'h00000000, 1'b0};
    vecs[4] = '{4'd8, 32'h00000000, 32'h00000000, 1'b0};
    vecs[5] = '{4'd8, 32'h7F800000, 32'h7F800000, 1'b1};
    vecs[6] = '{4'd3, 32'h3F800001, 32'h3F800001, 1'b1};
    vecs[7] = '{4'd9, 32'hC0000000, 32'h00000000, 1'b0};
    pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h7F800000,
             32'hFF800000, 32'h7FC00000, 32'h40000000, 32'h00000001, 32'hC0400000};

    rst = 1'b1; req_valid = 1'b0; req_state = '0; req_q = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_qmax", rsp_qmax, 32'd0);
    chk("rst_rsp_upd", 32'(rsp_updated), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_no_write", 32'(mem_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    init_check();

    // Directed single-request vectors.
    for (int i = 0; i < 8; i++) issue_check(vecs[i]);

    // Back-to-back same state: forwarding of the previous result.
    @(negedge clk); req_valid = 1'b1; req_state = 4'd5; req_q = 32'h40000000; model_apply(4'd5, req_q);
    @(negedge clk); req_q = 32'h3F800000; model_apply(4'd5, req_q);
    @(negedge clk); req_q = 32'h40400000; model_apply(4'd5, req_q);
    @(negedge clk); req_state = 4'd6; req_q = 32'h3F800000; model_apply(4'd6, req_q);
    @(negedge clk); req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_mem5", mem[5], 32'h40400000);
    chk("b2b_mem6", mem[6], 32'h3F800000);
    chk("b2b_drain", 32'(exp_q.size()), 32'd0);

    // Reset while stage 1 holds a writing request.
    @(negedge clk); req_valid = 1'b1; req_state = 4'd10; req_q = 32'h3F800000;
    @(negedge clk); req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(mem_write_en), 32'd0);
    @(negedge clk);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(init_busy), 32'd1);
    model_reset();
    rst = 1'b0;
    init_check();
    chk("rst_mid_mem10", mem[10], 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req_valid = ($urandom % 10) < 7;
      req_state = AW'($urandom % DEPTH);
      req_q = (($urandom % 4) == 0) ? $urandom : pool[$urandom % 10];
      if (req_valid && req_ready) model_apply(req_state, req_q);
    end
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    for (int s = 0; s < int'(DEPTH); s++) chk("final_mem", mem[s], qref[s]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qmax_update_ctrl.md
Name: qmax_update_ctrl

Overview:
- Sequencer in front of the Q-max BRAM: clears every entry after reset, then runs pipelined read-compare-conditional-write updates ("qmax[s] = max(qmax[s], q)") at one request per cycle.
- Resolves read-after-write hazards between back-to-back requests by forwarding.
- Sits between the Q-update datapath (requester) and the single-port-read/single-port-write Q-max BRAM, which has 1-cycle registered read latency.

Parameters:
ADDR_WIDTH, 16, state index width
DATA_WIDTH, 32, Q value width (IEEE-754 single)
DEPTH, 65536, number of entries swept at init
INIT_VALUE, 32'h00000000, value written to every entry during init

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  1  update request valid
o_req_ready  out  1  controller accepts request this cycle
i_req_state  in  ADDR_WIDTH  state index to update
i_req_q  in  DATA_WIDTH  candidate Q value (float32)
o_rsp_valid  out  1  one-cycle pulse, response fields valid
o_rsp_qmax  out  DATA_WIDTH  resolved max after this update
o_rsp_updated  out  1  1 = candidate was written
o_init_busy  out  1  init sweep in progress
o_mem_addr_r  out  ADDR_WIDTH  BRAM read address
o_mem_read_en  out  1  BRAM read enable
o_mem_addr_w  out  ADDR_WIDTH  BRAM write address
o_mem_write_en  out  1  BRAM write enable
o_mem_data  out  DATA_WIDTH  BRAM write data
i_mem_data  in  DATA_WIDTH  BRAM read data (valid 1 cycle after read_en)

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high.
- States: INIT, RUN. Reset forces INIT with sweep counter = 0.
- Reset values: o_rsp_valid=0, o_rsp_updated=0, o_rsp_qmax=0, o_init_busy=1, stage-1 valid=0, forward valid=0.
- INIT:
  - Each cycle: o_mem_write_en=1, o_mem_addr_w=counter, o_mem_data=INIT_VALUE; counter increments.
  - After the write of DEPTH-1, go to RUN. The sweep takes exactly DEPTH cycles.
  - o_req_ready=0 and o_init_busy=1 throughout INIT.
- RUN: o_init_busy=0, o_req_ready=1.
- Handshake: accept when i_req_valid && o_req_ready.
- Stage 0 (cycle t), combinational:
  - o_mem_read_en = accept; o_mem_addr_r = i_req_state.
  - On accept, register state and q into stage 1.
- Stage 1 (cycle t+1):
  - cur = forward value if fwd_valid && fwd_addr == s1_addr, else i_mem_data.
  - Compare: write when q > cur under IEEE float ordering:
    - +0 and -0 compare equal.
    - If either q or cur is NaN (exp=0xFF, mantissa≠0), no write.
    - Ties produce no write.
  - If write: o_mem_write_en=1, o_mem_addr_w=s1_addr, o_mem_data=q (combinational in t+1).
  - Resolved = write ? q : cur. Register forward {addr, resolved, valid=1} for use in t+2.
  - When stage 1 is not valid, forward valid clears.
- Response: in cycle t+2, o_rsp_valid=1 for one cycle, with o_rsp_qmax=resolved and o_rsp_updated=write. There is no response backpressure.
- Latency and throughput: request to response = 2 cycles; one request per cycle sustained.
- Forwarding window is exactly one request: a request two or more cycles later reads the BRAM directly, since the write has already landed.
- Read-port and write-port address equality in the same cycle is legal; the BRAM returns old data, which is covered by forwarding.
- Reset mid-operation:
  - In-flight stage-1 and response are discarded; no write is issued in the reset cycle.
  - The sweep restarts at address 0.
- i_req_valid during INIT is ignored and not queued.

Test Plan:
- Init, DEPTH=16: release reset → o_mem_write_en high for exactly 16 cycles with addr 0..15 and data 0, o_init_busy high for 16 cycles; o_req_ready rises in cycle 17.
- Single update: req state=3, q=0x3F800000 (1.0) → read addr 3; write addr 3 data 0x3F800000 in t+1; response qmax=0x3F800000, updated=1 at t+2.
- No write on smaller or equal value: entry 3=1.0, q=0xBF800000 (-1.0) → no write, qmax=0x3F800000, updated=0. q=0x80000000 (-0) vs stored 0 → no write.
- Back-to-back same address: state 5 with q=2.0 (0x40000000), then state 5 with q=1.0 next cycle → second response qmax=0x40000000, updated=0 via forwarding. Then 3.0 (0x40400000) → write, qmax=0x40400000.
- NaN: q=0x7FC00000 to state 7 → no write, updated=0, qmax=0.
- Reset mid-run: assert i_rst in the cycle stage 1 is valid with a writing request → no write or response that cycle; INIT sweep restarts at addr 0 and runs the full DEPTH cycles.
